if_stage_fifo: RTL

Parametrised instruction-fetch stage for the next-generation LoongArch core. It replaces the zero-latency instruction SRAM port of the single-cycle core with a split address/data SRAM-like handshake, so multiple fetches can be in flight. Returned instructions are buffered, with their PCs, in an in-order queue and delivered to decode over a valid/ready handshake. A redirect from execute (branch or jump) flushes the queue and discards stale responses.

---
 rtl/if_stage_fifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/if_stage_fifo.sv
// if_stage_fifo: instruction-fetch stage with a split address/data SRAM
// handshake. Fetches are allocated in an in-order ring when the address is
// accepted, filled as responses return, and handed to decode over a
// valid/ready handshake. A redirect flushes the ring and remembers how many
// in-flight responses must be thrown away when they eventually arrive.
module if_stage_fifo #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fs_valid,
  input  logic        fs_ready,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW:0]   C_DEPTH = DEPTH[CW:0];
  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};

  // Fetch PC and ring storage
  logic [31:0]      r_pc_q;
  logic [31:0]      r_ent_pc   [DEPTH];
  logic [31:0]      r_ent_inst [DEPTH];
  logic [DEPTH-1:0] r_filled;

  // Pointers carry one extra bit so full and empty are distinguishable
  logic [CW-1:0] r_alloc_ptr;
  logic [CW-1:0] r_fill_ptr;
  logic [CW-1:0] r_head_ptr;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] r_discard;

  logic [IW-1:0] w_alloc_idx;
  logic [IW-1:0] w_fill_idx;
  logic [IW-1:0] w_head_idx;
  logic [CW-1:0] w_unfilled;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_redirect_discard;
  logic          w_acc;
  logic          w_drop;
  logic          w_fill;
  logic          w_pop;
  logic          w_dok_owed;

  // Handshake decode, request gating and head-of-queue output selection
  always_comb begin
    w_alloc_idx    = r_alloc_ptr[IW-1:0];
    w_fill_idx     = r_fill_ptr[IW-1:0];
    w_head_idx     = r_head_ptr[IW-1:0];
    w_unfilled     = r_alloc_ptr - r_fill_ptr;
    // req depends only on state and reset, never on fs_ready
    w_inflight     = {1'b0, r_occ} + {1'b0, r_discard};
    inst_sram_req  = ~reset & (w_inflight < C_DEPTH);
    inst_sram_addr = r_pc_q;
    w_acc          = inst_sram_req & inst_sram_addr_ok;
    w_drop         = inst_sram_data_ok & (r_discard != C_ZERO);
    w_fill         = inst_sram_data_ok & (r_discard == C_ZERO) & (w_unfilled != C_ZERO);
    fs_valid       = r_filled[w_head_idx];
    fs_pc          = r_ent_pc[w_head_idx];
    fs_inst        = r_ent_inst[w_head_idx];
    w_pop          = fs_valid & fs_ready;
    // A response only reduces the owed count if something was actually owed
    w_dok_owed     = inst_sram_data_ok & ((r_discard != C_ZERO) | (w_unfilled != C_ZERO));
    w_redirect_discard = r_discard + w_unfilled
                       + (w_acc ? C_ONE : C_ZERO)
                       - (w_dok_owed ? C_ONE : C_ZERO);
  end

  // Fetch PC, pointers, occupancy and stale-response bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_q      <= RESET_PC;
      r_alloc_ptr <= C_ZERO;
      r_fill_ptr  <= C_ZERO;
      r_head_ptr  <= C_ZERO;
      r_occ       <= C_ZERO;
      r_discard   <= C_ZERO;
    end else if (redirect_valid) begin
      r_pc_q      <= redirect_pc;
      r_alloc_ptr <= C_ZERO;
      r_fill_ptr  <= C_ZERO;
      r_head_ptr  <= C_ZERO;
      r_occ       <= C_ZERO;
      r_discard   <= w_redirect_discard;
    end else begin
      if (w_acc) begin
        r_pc_q      <= r_pc_q + 32'd4;
        r_alloc_ptr <= r_alloc_ptr + C_ONE;
      end
      if (w_drop) begin
        r_discard <= r_discard - C_ONE;
      end
      if (w_fill) begin
        r_fill_ptr <= r_fill_ptr + C_ONE;
      end
      if (w_pop) begin
        r_head_ptr <= r_head_ptr + C_ONE;
      end
      r_occ <= r_occ + (w_acc ? C_ONE : C_ZERO) - (w_pop ? C_ONE : C_ZERO);
    end
  end

  // Entry payload: PC captured on allocation, instruction captured on fill
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent_pc[i]   <= 32'h0;
        r_ent_inst[i] <= 32'h0;
      end
    end else if (!redirect_valid) begin
      if (w_acc) begin
        r_ent_pc[w_alloc_idx] <= r_pc_q;
      end
      if (w_fill) begin
        r_ent_inst[w_fill_idx] <= inst_sram_rdata;
      end
    end
  end

  // Filled flags: set on fill, cleared on pop; alloc, fill and pop always
  // touch distinct entries so the updates never collide
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      r_filled <= {DEPTH{1'b0}};
    end else begin
      if (w_acc) begin
        r_filled[w_alloc_idx] <= 1'b0;
      end
      if (w_fill) begin
        r_filled[w_fill_idx] <= 1'b1;
      end
      if (w_pop) begin
        r_filled[w_head_idx] <= 1'b0;
      end
    end
  end

endmodule
